// File: rtl/store_merger.sv
`default_nettype none
// ============================================================================
// Module      : store_merger
// Description : Store-path merger between the MEM stage and a word-wide data
//               RAM that has no byte enables. Word stores are written
//               directly. Byte and halfword stores read the containing word,
//               replace the addressed lane and write the merged word back.
//               The pipeline is stalled through valid/ready handshakes.
//
// Ports       : clk, rstn              clock, asynchronous active-low reset
//               req_valid/req_ready    store request handshake
//               req_addr, req_wdata    byte address, right-aligned store data
//               req_mode               000 word, 001/010 byte, 011/100 half,
//                                      101-111 word
//               mem_addr, mem_re       word address and read strobe to RAM
//               mem_rdata              RAM data, valid the cycle after mem_re
//               mem_we, mem_wdata      write strobe and merged write word
//               resp_valid, resp_err   completion and misalignment flag
//               resp_ready             pipeline consumes the response
//
// Config      : `STORE_MISALIGN_TRAP_EN  when defined, misaligned half/word
//               stores complete at once with resp_err=1 and leave memory
//               untouched. When undefined, resp_err is tied to 0.
//
// Revision    : 1.0  initial release
// ============================================================================
module store_merger (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_mode,
    output logic [31:0] mem_addr,
    output logic        mem_re,
    input  logic [31:0] mem_rdata,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    input  logic        resp_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q,  addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  mode_q,  mode_d;

    // Width decode of the incoming and the latched mode. Codes 101-111
    // fall through to word.
    logic req_is_byte, req_is_half, req_is_word;
    logic lat_is_byte, lat_is_half;

    assign req_is_byte = (req_mode == 3'b001) || (req_mode == 3'b010);
    assign req_is_half = (req_mode == 3'b011) || (req_mode == 3'b100);
    assign req_is_word = !req_is_byte && !req_is_half;
    assign lat_is_byte = (mode_q == 3'b001) || (mode_q == 3'b010);
    assign lat_is_half = (mode_q == 3'b011) || (mode_q == 3'b100);

`ifdef STORE_MISALIGN_TRAP_EN
    logic err_q, err_d;
    logic req_misaligned;

    assign req_misaligned = (req_is_half && req_addr[0]) ||
                            (req_is_word && (req_addr[1:0] != 2'b00));
`endif

    // ------------------------------------------------------------------
    // State and request registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            mode_q  <= 3'd0;
`ifdef STORE_MISALIGN_TRAP_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mode_q  <= mode_d;
`ifdef STORE_MISALIGN_TRAP_EN
            err_q   <= err_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mode_d  = mode_q;
`ifdef STORE_MISALIGN_TRAP_EN
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    mode_d  = req_mode;
                    state_d = req_is_word ? WRITE : READ;
`ifdef STORE_MISALIGN_TRAP_EN
                    err_d   = req_misaligned;
                    if (req_misaligned) begin
                        state_d = DONE;
                    end
`endif
                end
            end
            READ:    state_d = WRITE;
            WRITE:   state_d = DONE;
            DONE: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs. All strobes decode straight from the state register, so the
    // asynchronous reset drops mem_we without waiting for a clock edge.
    // ------------------------------------------------------------------
    logic [31:0] merged;

    always_comb begin
        merged = wdata_q;
        if (lat_is_byte) begin
            merged = mem_rdata;
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end else if (lat_is_half) begin
            // addr[0] is ignored here; a misaligned half either trapped at
            // accept or is deliberately written to lane addr[1].
            merged = mem_rdata;
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign mem_re     = (state_q == READ);
    assign mem_we     = (state_q == WRITE);
    assign mem_addr   = (state_q == READ || state_q == WRITE) ?
                        {addr_q[31:2], 2'b00} : 32'd0;
    assign mem_wdata  = (state_q == WRITE) ? merged : 32'd0;
    assign resp_valid = (state_q == DONE);
`ifdef STORE_MISALIGN_TRAP_EN
    assign resp_err   = (state_q == DONE) && err_q;
`else
    assign resp_err   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_store_merger.sv
`default_nettype none
// ============================================================================
// Module      : tb_store_merger
// Description : Directed self-checking bench for store_merger with a small
//               synchronous RAM model. Expected values are hand-computed.
// Revision    : 1.0  initial release
// ============================================================================
module tb_store_merger;

    logic        clk;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_mode;
    logic [31:0] mem_addr;
    logic        mem_re;
    logic [31:0] mem_rdata;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic        resp_ready;

    int checks = 0;
    int errors = 0;

    store_merger u_dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_mode   (req_mode),
        .mem_addr   (mem_addr),
        .mem_re     (mem_re),
        .mem_rdata  (mem_rdata),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_ready (resp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM model, 256 words; the bench can preload word 0x200.
    logic [31:0] ram [0:255];
    logic        poke;
    logic [31:0] poke_val;

    always @(posedge clk) begin
        if (mem_re) mem_rdata <= ram[mem_addr[9:2]];
        if (mem_we) ram[mem_addr[9:2]] <= mem_wdata;
        else if (poke) ram[8'h80] <= poke_val;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [31:0] val);
        poke     = 1'b1;
        poke_val = val;
        @(posedge clk);
        @(negedge clk);
        poke     = 1'b0;
    endtask

    // Issues one store at a negedge with resp_ready high and checks every
    // cycle of it. sub: expect a READ cycle; trap: expect immediate error.
    task automatic run_store(input string tag, input logic [31:0] a, input logic [31:0] d,
                             input logic [2:0] m, input bit sub, input bit trap,
                             input logic [31:0] exp_w);
        check({tag, " req_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_addr  = a;
        req_wdata = d;
        req_mode  = m;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        if (trap) begin
            check({tag, " resp_valid"}, {31'd0, resp_valid}, 32'd1);
            check({tag, " resp_err"},   {31'd0, resp_err},   32'd1);
            check({tag, " mem_we"},     {31'd0, mem_we},     32'd0);
            check({tag, " mem_re"},     {31'd0, mem_re},     32'd0);
        end else begin
            if (sub) begin
                check({tag, " mem_re"},   {31'd0, mem_re}, 32'd1);
                check({tag, " rd_addr"},  mem_addr, {a[31:2], 2'b00});
                check({tag, " we_early"}, {31'd0, mem_we}, 32'd0);
                @(posedge clk);
                @(negedge clk);
            end
            check({tag, " no_re"},     {31'd0, mem_re}, 32'd0);
            check({tag, " mem_we"},    {31'd0, mem_we}, 32'd1);
            check({tag, " wr_addr"},   mem_addr, {a[31:2], 2'b00});
            check({tag, " mem_wdata"}, mem_wdata, exp_w);
            @(posedge clk);
            @(negedge clk);
            check({tag, " resp_valid"}, {31'd0, resp_valid}, 32'd1);
            check({tag, " resp_err"},   {31'd0, resp_err},   32'd0);
            check({tag, " we_done"},    {31'd0, mem_we},     32'd0);
        end
        @(posedge clk);
        @(negedge clk);
        check({tag, " resp_pulse"}, {31'd0, resp_valid}, 32'd0);
        check({tag, " back_idle"},  {31'd0, req_ready},  32'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " req_ready"},  {31'd0, req_ready},  32'd1);
        check({tag, " mem_re"},     {31'd0, mem_re},     32'd0);
        check({tag, " mem_we"},     {31'd0, mem_we},     32'd0);
        check({tag, " resp_valid"}, {31'd0, resp_valid}, 32'd0);
        check({tag, " resp_err"},   {31'd0, resp_err},   32'd0);
        check({tag, " mem_addr"},   mem_addr,            32'd0);
        check({tag, " mem_wdata"},  mem_wdata,           32'd0);
    endtask

    initial begin
        rstn       = 1'b0;
        req_valid  = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        req_mode   = 3'd0;
        resp_ready = 1'b1;
        poke       = 1'b0;
        poke_val   = 32'd0;
        mem_rdata  = 32'd0;
        for (int i = 0; i < 256; i++) ram[i] = 32'd0;

        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        rstn = 1'b1;
        @(negedge clk);

        // Word store
        run_store("word", 32'h0000_0100, 32'hDEAD_BEEF, 3'b000, 1'b0, 1'b0, 32'hDEAD_BEEF);
        check("word ram", ram[8'h40], 32'hDEAD_BEEF);

        // Code 111 behaves as a word store
        run_store("word111", 32'h0000_0100, 32'h1234_5678, 3'b111, 1'b0, 1'b0, 32'h1234_5678);

        // Byte store, lane 2
        preload(32'h1122_3344);
        run_store("byte", 32'h0000_0202, 32'h0000_00AB, 3'b001, 1'b1, 1'b0, 32'h11AB_3344);
        check("byte ram", ram[8'h80], 32'h11AB_3344);

        // Byte store with the other byte code, lane 1
        preload(32'h1122_3344);
        run_store("byte010", 32'h0000_0201, 32'h0000_0055, 3'b010, 1'b1, 1'b0, 32'h1122_5544);

        // Half store, upper lane
        preload(32'h1122_3344);
        run_store("half", 32'h0000_0202, 32'hFFFF_CAFE, 3'b100, 1'b1, 1'b0, 32'hCAFE_3344);
        check("half ram", ram[8'h80], 32'hCAFE_3344);

        // Misaligned half store
        preload(32'h1122_3344);
`ifdef STORE_MISALIGN_TRAP_EN
        run_store("mis_half", 32'h0000_0203, 32'hFFFF_CAFE, 3'b011, 1'b0, 1'b1, 32'd0);
        check("mis_half ram", ram[8'h80], 32'h1122_3344);
`else
        run_store("mis_half", 32'h0000_0203, 32'hFFFF_CAFE, 3'b011, 1'b1, 1'b0, 32'hCAFE_3344);
        check("mis_half ram", ram[8'h80], 32'hCAFE_3344);
`endif

        // Back-pressure on the response
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_addr   = 32'h0000_0104;
        req_wdata  = 32'hA5A5_5A5A;
        req_mode   = 3'b000;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("bp resp_valid", {31'd0, resp_valid}, 32'd1);
            check("bp req_ready",  {31'd0, req_ready},  32'd0);
            @(posedge clk);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        check("bp release_valid", {31'd0, resp_valid}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("bp idle",      {31'd0, req_ready},  32'd1);
        check("bp resp_drop", {31'd0, resp_valid}, 32'd0);
        check("bp ram",       ram[8'h41],          32'hA5A5_5A5A);

        // Reset during the WRITE cycle of a byte store
        preload(32'h1122_3344);
        req_valid = 1'b1;
        req_addr  = 32'h0000_0200;
        req_wdata = 32'h0000_0077;
        req_mode  = 3'b001;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst we_before", {31'd0, mem_we}, 32'd1);
        rstn = 1'b0;
        #1;
        check("rst we_async", {31'd0, mem_we}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        check_idle_outputs("post_rst");
        check("rst ram_untouched", ram[8'h80], 32'h1122_3344);
        @(negedge clk);

        // Unit still works after the mid-operation reset
        run_store("after_rst", 32'h0000_0200, 32'h0000_0077, 3'b001, 1'b1, 1'b0, 32'h1122_3377);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
